led_pattern_gen: RTL and testbench

Parametrised LED pattern generator for the board PMOD LED bank. It replaces the fixed 4-bit free-running counter with a generic-width generator that has a programmable prescaler, four display modes, enable/single-step control and a synchronous clear. It sits between the top-level `chip` and the PMOD LED pins. It is driven directly from the 100 MHz `clk` and the global reset.

---
 rtl/led_pattern_gen.sv | 138 +++++++++++++
 tb/tb_led_pattern_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
`default_nettype none
// =============================================================================
// led_pattern_gen : PMOD LED pattern generator with prescaler, four display
//                   modes (binary up/down, Gray up, bounce) and step control.
// Revision 1.0
// =============================================================================
module led_pattern_gen #(
   parameter int WIDTH = 4,
   parameter int DIV   = 25_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             step,
   input  logic             clear,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] leds,
   output logic             tick
);

   localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [PRE_W-1:0] C_PRE_LAST    = PRE_W'(DIV - 1);
   localparam logic [POS_W-1:0] C_POS_LAST    = POS_W'(WIDTH - 1);
   localparam logic [1:0]       C_MODE_UP     = 2'd0;
   localparam logic [1:0]       C_MODE_DOWN   = 2'd1;
   localparam logic [1:0]       C_MODE_GRAY   = 2'd2;
   localparam logic [1:0]       C_MODE_BOUNCE = 2'd3;

   logic [PRE_W-1:0] pre_q,  pre_d;
   logic [WIDTH-1:0] cnt_q,  cnt_d;
   logic [POS_W-1:0] pos_q,  pos_d;
   logic             dir_q,  dir_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] leds_q, leds_d;
   logic             tick_q, tick_d;
   logic             advance;

   assign leds = leds_q;
   assign tick = tick_q;

   always_comb begin
      pre_d   = pre_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
      leds_d  = leds_q;
      tick_d  = 1'b0;
      advance = 1'b0;

      if (clear) begin
         pre_d  = '0;
         cnt_d  = '0;
         pos_d  = '0;
         dir_d  = 1'b0;
         mode_d = mode;
         leds_d = '0;
      end else begin
         if (enable) begin
            if (pre_q == C_PRE_LAST) begin
               pre_d   = '0;
               advance = 1'b1;
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
         end else if (step) begin
            advance = 1'b1;
         end

         if (advance) begin
            tick_d = 1'b1;
            mode_d = mode;
            case (mode)
               C_MODE_UP: begin
                  cnt_d  = cnt_q + WIDTH'(1);
                  leds_d = cnt_d;
               end
               C_MODE_DOWN: begin
                  cnt_d  = cnt_q - WIDTH'(1);
                  leds_d = cnt_d;
               end
               C_MODE_GRAY: begin
                  cnt_d  = cnt_q + WIDTH'(1);
                  leds_d = cnt_d ^ (cnt_d >> 1);
               end
               default: begin
                  // Bounce: entering restarts at LED 0; the count register is left frozen.
                  if (mode_q != C_MODE_BOUNCE) begin
                     pos_d = '0;
                     dir_d = 1'b0;
                  end else if (WIDTH > 1) begin
                     if (!dir_q) begin
                        if (pos_q == C_POS_LAST) begin
                           dir_d = 1'b1;
                           pos_d = pos_q - POS_W'(1);
                        end else begin
                           pos_d = pos_q + POS_W'(1);
                        end
                     end else begin
                        if (pos_q == '0) begin
                           dir_d = 1'b0;
                           pos_d = pos_q + POS_W'(1);
                        end else begin
                           pos_d = pos_q - POS_W'(1);
                        end
                     end
                  end
                  leds_d = WIDTH'(1) << pos_d;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q  <= '0;
         cnt_q  <= '0;
         pos_q  <= '0;
         dir_q  <= 1'b0;
         mode_q <= 2'd0;
         leds_q <= '0;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         cnt_q  <= cnt_d;
         pos_q  <= pos_d;
         dir_q  <= dir_d;
         mode_q <= mode_d;
         leds_q <= leds_d;
         tick_q <= tick_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// =============================================================================
// tb_led_pattern_gen : randomized bench for led_pattern_gen (4-bit/DIV=4 and
//                      1-bit/DIV=1 instances) against a behavioural model.
// Revision 1.0
// =============================================================================
module tb_led_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       step;
   logic       clear;
   logic [1:0] mode;
   logic [3:0] leds_a;
   logic       tick_a;
   logic [0:0] leds_b;
   logic       tick_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   led_pattern_gen #(.WIDTH(4), .DIV(4)) u_dut_a (
      .clk(clk), .rst(rst), .enable(enable), .step(step), .clear(clear),
      .mode(mode), .leds(leds_a), .tick(tick_a)
   );

   led_pattern_gen #(.WIDTH(1), .DIV(1)) u_dut_b (
      .clk(clk), .rst(rst), .enable(enable), .step(step), .clear(clear),
      .mode(mode), .leds(leds_b), .tick(tick_b)
   );

   // Model state: prescale count, counter value, index into the bounce
   // cycle (0..2*(W-1)-1), whether the last advance mode was bounce.
   typedef struct {
      int pre;
      int cnt;
      int k;
      bit bnc;
      int leds;
      bit tick;
   } mstate_t;

   mstate_t ma, mb;

   function automatic mstate_t model_reset();
      mstate_t s;
      s.pre = 0; s.cnt = 0; s.k = 0; s.bnc = 1'b0; s.leds = 0; s.tick = 1'b0;
      return s;
   endfunction

   function automatic mstate_t model_step(mstate_t s, int w, int d,
                                          bit en, bit st, bit clr, int md);
      mstate_t n = s;
      bit adv = 1'b0;
      int modv = 1 << w;
      int per = 2 * (w - 1);
      int p;
      n.tick = 1'b0;
      if (clr) begin
         n = model_reset();
         n.bnc = (md == 3);
         return n;
      end
      if (en) begin
         if (s.pre == d - 1) begin
            n.pre = 0;
            adv = 1'b1;
         end else begin
            n.pre = s.pre + 1;
         end
      end else if (st) begin
         adv = 1'b1;
      end
      if (adv) begin
         n.tick = 1'b1;
         if (md == 0) begin
            n.cnt = (s.cnt + 1) % modv;
            n.leds = n.cnt;
         end else if (md == 1) begin
            n.cnt = (s.cnt + modv - 1) % modv;
            n.leds = n.cnt;
         end else if (md == 2) begin
            n.cnt = (s.cnt + 1) % modv;
            n.leds = n.cnt ^ (n.cnt >> 1);
         end else begin
            if (!s.bnc) n.k = 0;
            else if (w > 1) n.k = (s.k + 1) % per;
            p = (n.k < w) ? n.k : per - n.k;
            n.leds = 1 << p;
         end
         n.bnc = (md == 3);
      end
      return n;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check_val("a_leds", {28'd0, leds_a}, ma.leds);
      check_val("a_tick", {31'd0, tick_a}, {31'd0, ma.tick});
      check_val("b_leds", {31'd0, leds_b}, mb.leds);
      check_val("b_tick", {31'd0, tick_b}, {31'd0, mb.tick});
   endtask

   task automatic run_cycle();
      @(posedge clk);
      ma = model_step(ma, 4, 4, enable, step, clear, int'(mode));
      mb = model_step(mb, 1, 1, enable, step, clear, int'(mode));
      #1;
      check_outputs();
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   // Pulls reset low between edges and expects outputs to clear at once.
   task automatic async_reset();
      #3 rst = 1'b0;
      #1;
      check_val("rst_a_leds", {28'd0, leds_a}, 32'd0);
      check_val("rst_a_tick", {31'd0, tick_a}, 32'd0);
      check_val("rst_b_leds", {31'd0, leds_b}, 32'd0);
      check_val("rst_b_tick", {31'd0, tick_b}, 32'd0);
      ma = model_reset();
      mb = model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; step = 1'b0; clear = 1'b0; mode = 2'd0;
      ma = model_reset();
      mb = model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
      rst = 1'b1;

      // Free-running binary up, through a full wrap.
      enable = 1'b1;
      run_n(70);
      // Down, Gray, bounce, then back to a count mode mid-bounce.
      mode = 2'd1; run_n(14);
      mode = 2'd2; run_n(40);
      mode = 2'd3; run_n(42);
      mode = 2'd0; run_n(10);

      // Hold with enable low, a single step, then steps while enabled.
      enable = 1'b0;
      run_n(50);
      step = 1'b1; run_cycle();
      step = 1'b0; run_n(5);
      enable = 1'b1; step = 1'b1; run_n(9);
      step = 1'b0;

      // Clear during enabled running.
      run_n(3);
      clear = 1'b1; run_cycle();
      clear = 1'b0; run_n(10);

      // Reset mid-count, then restart.
      run_n(2);
      async_reset();
      mode = 2'd0; enable = 1'b1;
      run_n(12);

      // Randomized mix of all controls.
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 3) != 0);
         step   = ($urandom_range(0, 3) == 0);
         clear  = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         run_cycle();
         if ($urandom_range(0, 499) == 0) async_reset();
      end

      enable = 1'b1; step = 1'b0; clear = 1'b0; mode = 2'd0;
      run_n(6);
      async_reset();
      run_n(10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
